// File: rtl/lsu_retire_merge_pkg.sv
// Shared definitions for the LSU retire merge: wavefront sizing and the
// completion-source encoding used by the round-robin arbiter.
package lsu_retire_merge_pkg;

    localparam int unsigned WF_PER_CU  = 40;
    localparam int unsigned WFID_WIDTH = 6;

    // Completion source; also the encoding of the arbiter's last-grant bit.
    typedef enum logic {
        SRC_SGPR = 1'b0,
        SRC_VGPR = 1'b1
    } src_e;

endpackage

// File: rtl/lsu_done_fifo.sv
// Per-source FIFO of completed wavefront ids.  A push into a full FIFO is
// accepted only when the same FIFO is popped in that cycle; otherwise it is
// dropped and flagged on 'drop'.
module lsu_done_fifo
    import lsu_retire_merge_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WFID_W = WFID_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WFID_W-1:0] din,
    input  logic              pop,
    output logic [WFID_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic              drop
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WFID_W-1:0] mem_q [DEPTH];
    logic              wr_en;
    logic              rd_en;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign drop  = push && full && !pop;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
    // When full with a same-cycle pop, the write lands on the slot being
    // read, which is safe because dout is taken before the edge.
    always_comb begin
        wr_en    = push && (!full || pop);
        rd_en    = pop && !empty;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer/count registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/lsu_retire_merge.sv
// Merges SGPR-retire and VGPR-write-done completions into one lsu_done
// pulse stream for the memory-wait tracker, one retire per cycle, with
// round-robin arbitration between the two buffered sources.
module lsu_retire_merge
    import lsu_retire_merge_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned WFID_W = WFID_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sgpr_done,
    input  logic [WFID_W-1:0] sgpr_done_wfid,
    input  logic              vgpr_done,
    input  logic [WFID_W-1:0] vgpr_done_wfid,
    output logic              sgpr_full,
    output logic              vgpr_full,
    output logic              lsu_done,
    output logic [WFID_W-1:0] lsu_done_wfid,
    output logic              overflow_err
);

    logic [WFID_W-1:0] s_head, v_head;
    logic              s_empty, v_empty;
    logic              s_drop, v_drop;
    logic              grant_s, grant_v;

    src_e              last_grant_q, last_grant_d;
    logic              done_q, done_d;
    logic [WFID_W-1:0] wfid_q, wfid_d;
    logic              overflow_q, overflow_d;

    lsu_done_fifo #(.DEPTH(DEPTH), .WFID_W(WFID_W)) u_sgpr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (sgpr_done),
        .din   (sgpr_done_wfid),
        .pop   (grant_s),
        .dout  (s_head),
        .empty (s_empty),
        .full  (sgpr_full),
        .drop  (s_drop)
    );

    lsu_done_fifo #(.DEPTH(DEPTH), .WFID_W(WFID_W)) u_vgpr_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (vgpr_done),
        .din   (vgpr_done_wfid),
        .pop   (grant_v),
        .dout  (v_head),
        .empty (v_empty),
        .full  (vgpr_full),
        .drop  (v_drop)
    );

    // Round-robin grant: a lone requester wins, a tie goes to the source
    // that was not granted last.
    always_comb begin
        grant_s = 1'b0;
        grant_v = 1'b0;
        if (!s_empty && !v_empty) begin
            if (last_grant_q == SRC_VGPR) grant_s = 1'b1;
            else                          grant_v = 1'b1;
        end else begin
            grant_s = !s_empty;
            grant_v = !v_empty;
        end
    end

    // Next state for the output register, last-grant bit and sticky overflow.
    always_comb begin
        last_grant_d = last_grant_q;
        done_d       = 1'b0;
        wfid_d       = wfid_q;
        overflow_d   = overflow_q | s_drop | v_drop;
        if (grant_s) begin
            last_grant_d = SRC_SGPR;
            done_d       = 1'b1;
            wfid_d       = s_head;
        end else if (grant_v) begin
            last_grant_d = SRC_VGPR;
            done_d       = 1'b1;
            wfid_d       = v_head;
        end
    end

    // Output and arbiter state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= SRC_VGPR;
            done_q       <= 1'b0;
            wfid_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            done_q       <= done_d;
            wfid_q       <= wfid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign lsu_done      = done_q;
    assign lsu_done_wfid = wfid_q;
    assign overflow_err  = overflow_q;

endmodule
